int_fp_converter: RTL and testbench



---
 rtl/int_fp_converter.sv | 90 +++++++++
 tb/tb_int_fp_converter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/int_fp_converter.sv
// Unsigned integer to IEEE-754 single-precision converter.
// The operand is normalised one left-shift per cycle until its leading one reaches the MSB.
module int_fp_converter #(
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [IN_WIDTH-1:0] in_number,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [31:0]         fp_number,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
);

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        DONE
    } state_t;

    localparam int          ZW       = 24 - IN_WIDTH;
    localparam logic [7:0]  EXP_INIT = 8'(127 + IN_WIDTH - 1);

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   sh_q, sh_d;
    logic [7:0]            exp_q, exp_d;
    logic [31:0]           fp_q, fp_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_q    <= '0;
            exp_q   <= '0;
            fp_q    <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            exp_q   <= exp_d;
            fp_q    <= fp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        exp_d   = exp_q;
        fp_d    = fp_q;
        case (state_q)
            IDLE: begin
                if (in_valid && in_ready) begin
                    if (in_number == '0) begin
                        fp_d    = 32'h0000_0000;
                        state_d = DONE;
                    end else begin
                        sh_d    = in_number;
                        exp_d   = EXP_INIT;
                        state_d = NORM;
                    end
                end
            end
            NORM: begin
                // The hidden one is dropped; the remaining bits are the exact mantissa.
                if (sh_q[IN_WIDTH-1]) begin
                    fp_d    = {1'b0, exp_q, sh_q[IN_WIDTH-2:0], {ZW{1'b0}}};
                    state_d = DONE;
                end else begin
                    sh_d  = sh_q << 1;
                    exp_d = exp_q - 8'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by rst_n so the source sees not-ready while reset is asserted.
    assign in_ready  = (state_q == IDLE) && rst_n;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign fp_number = fp_q;

endmodule

// File: tb/tb_int_fp_converter.sv
// Directed and sweep bench for int_fp_converter with IN_WIDTH=8.
module tb_int_fp_converter;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_number;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] fp_number;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int checks;
    int failures;

    int_fp_converter #(.IN_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_number (in_number),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .fp_number (fp_number),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_float(input logic [7:0] v);
        int m;
        logic [31:0] man;
        logic [7:0]  e;
        if (v == 8'd0) return 32'h0;
        m = 0;
        for (int i = 0; i < 8; i++) if (v[i]) m = i;
        e   = 8'(127 + m);
        man = (32'(v) << (23 - m)) & 32'h007F_FFFF;
        return {1'b0, e, man[22:0]};
    endfunction

    function automatic logic [31:0] float_to_int(input logic [31:0] f);
        int e;
        if (f == 32'h0) return 32'h0;
        e = int'(f[30:23]);
        return {8'h0, 1'b1, f[22:0]} >> (150 - e);
    endfunction

    // Accept v, measure latency, then complete the output handshake.
    task automatic convert(input logic [7:0] v, input bit rnd, output logic [31:0] res, output int lat);
        int  n;
        bit  stable;
        bit  taken;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
        in_number = v;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_number = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        res    = fp_number;
        stable = 1'b1;
        n      = 0;
        do begin
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            taken     = out_ready;
            if (fp_number !== res || !out_valid || in_ready) stable = 1'b0;
            @(posedge clk); #1;
            n++;
        end while (!taken && n < 50);
        check("hold_stable", 32'(stable), 32'd1);
        check("valid_dropped", 32'(out_valid), 32'd0);
        $display("conv in=%02h fp=%08h lat=%0d", v, res, lat);
    endtask

    logic [7:0]  dir_in  [6] = '{8'h00, 8'h01, 8'h05, 8'h64, 8'h80, 8'hFF};
    logic [31:0] dir_fp  [6] = '{32'h00000000, 32'h3F800000, 32'h40A00000,
                                 32'h42C80000, 32'h43000000, 32'h437F0000};
    int          dir_lat [6] = '{1, 9, 7, 3, 2, 2};

    initial begin
        logic [31:0] res;
        int          lat;
        bit          seen;
        int          n;
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        in_number = 8'h0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_fp", fp_number, 32'h0);
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 6; i++) begin
            convert(dir_in[i], 1'b0, res, lat);
            check($sformatf("dir_fp_%02h", dir_in[i]), res, dir_fp[i]);
            check($sformatf("dir_lat_%02h", dir_in[i]), 32'(lat), 32'(dir_lat[i]));
        end

        // Asynchronous reset mid-NORM; fp_number still holds the 0xFF result.
        in_number = 8'h01;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_fp", fp_number, 32'h0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid || busy) seen = 1'b1;
        end
        check("no_stale_output", 32'(seen), 32'd0);
        $display("reset mid-conversion done");

        // Back-pressure on 0x64.
        out_ready = 1'b0;
        in_number = 8'h64;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        for (int c = 0; c < 10; c++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_fp", fp_number, 32'h42C80000);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_released_valid", 32'(out_valid), 32'd0);
        check("bp_idle", 32'(in_ready), 32'd1);
        $display("backpressure 64 fp=42c80000 held 10 cycles");

        // Input stall: 0xAA offered while busy must be ignored.
        out_ready = 1'b0;
        in_number = 8'h01;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_number = 8'hAA;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("stall_first_fp", fp_number, 32'h3F800000);
        in_number = 8'h33;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("stall_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("stall_fp_33", fp_number, 32'h424C0000);
        @(posedge clk); #1;
        $display("stall conv in=33 fp=%08h", fp_number);

        // Back-to-back stream.
        convert(8'hFF, 1'b0, res, lat);
        check("b2b_fp_ff", res, 32'h437F0000);
        check("b2b_ready_next", 32'(in_ready), 32'd1);
        convert(8'h01, 1'b0, res, lat);
        check("b2b_fp_01", res, 32'h3F800000);
        check("b2b_lat_01", 32'(lat), 32'd9);

        // Exhaustive sweep with random back-pressure.
        for (int v = 0; v < 256; v++) begin
            convert(8'(v), 1'b1, res, lat);
            check($sformatf("sweep_fp_%02h", v), res, ref_float(8'(v)));
            check($sformatf("sweep_back_%02h", v), float_to_int(res), 32'(v));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
